exe_div_ctrl: RTL
=================

# exe_div_ctrl

Iterative 32-bit integer divider controller for the EXE stage. It sequences a shift/trial-subtract datapath over a fixed number of cycles for div.w, mod.w, div.wu and mod.wu. It exposes valid/ready handshakes on both the operand and result sides and a busy flag that the EXE stage uses to stall. The single-cycle ALU continues to handle all other arithmetic; this block serves only the divide/modulo instructions.

## Interface
- Parameters: none; width fixed at 32.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- div_valid  in  1  operands and op valid
- div_ready  out  1  block can accept; high only in IDLE and not in reset
- div_op  in  2  00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
- div_src1  in  32  dividend (rj)
- div_src2  in  32  divisor (rk)
- div_flush  in  1  cancel in-flight operation (exception/ertn)
- res_valid  out  1  div_result valid
- res_ready  in  1  consumer accepts result
- div_result  out  32  quotient or remainder
- div_busy  out  1  state != IDLE

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - Accept on div_valid & div_ready & ~div_flush.
  - Latch op, sign flags s1 = src1[31] & signed and s2 = src2[31] & signed, absolute values of both sources, and divzero = (src2 == 0).
  - Set quo = |src1|, rem = 0, cnt = 0. Go to ITER.
- ITER, one bit per cycle:
  - trial = {rem, quo[31]} − {1'b0, |src2|}, 33-bit.
  - If trial[32] == 0: rem = trial[31:0], new quotient bit = 1.
  - Else: rem = {rem[30:0], quo[31]}, new quotient bit = 0.
  - quo = {quo[30:0], bit}; cnt++.
  - After the cnt == 31 step, go to FIX.
- FIX: register div_result, then go to DONE.
  - Quotient = (s1 ^ s2) ? −quo : quo.
  - Remainder = s1 ? −rem : rem.
  - divzero overrides: quotient 0xFFFFFFFF; remainder = original div_src1 (latched raw).
  - Signed overflow 0x80000000 / 0xFFFFFFFF falls out naturally: quotient 0x80000000, remainder 0.
- DONE:
  - res_valid = 1; div_result held stable.
  - On res_ready, go to IDLE. No accept in the same cycle, because div_ready is low in DONE.
- div_flush:
  - Any state goes to IDLE at the next edge; res_valid drops.
  - Flush beats a simultaneous res_ready (result discarded) and a simultaneous div_valid (not accepted).
- reset:
  - Dominates flush; state IDLE; all outputs 0.
  - div_ready is 0 while reset is high and rises the first cycle after reset deasserts.

## Timing
- Accept at edge E0; iterations at E1..E32; FIX at E33.
- res_valid is high in the cycle after E33: fixed 33-cycle latency independent of operands, including divzero.
- Minimum issue interval is 35 cycles, with one IDLE cycle between a result handshake and the next accept.
- Reset values:
  - div_ready 0, then 1 from the first post-reset cycle.
  - res_valid 0, div_result 0, div_busy 0.
- div_busy is a registered state decode: high from the cycle after accept until the cycle after the result handshake or flush.
- Outputs are registered or pure state decodes; there is no combinational path from inputs to outputs.
- Reset mid-operation behaves identically to flush, with outputs also cleared.

## Structure
- Shared header macros: DIV_OP encodings (DIV_W, MOD_W, DIV_WU, MOD_WU) and the 2-bit state encodings, so the decoder and EXE stage use the same values.
- One sub-module, div_iter_step: purely combinational 33-bit trial subtract producing next rem/quo.
- The FSM, counter, sign fix-up and handshakes stay in exe_div_ctrl.

## Test plan
- div.w 7 / 0xFFFFFFFE → 0xFFFFFFFD after 33 cycles; mod.w same operands → 0x00000001.
- mod.w 0xFFFFFFF9 / 2 → 0xFFFFFFFF; div.wu 0xFFFFFFFF / 0x10 → 0x0FFFFFFF; mod.wu same → 0x0000000F.
- Divide by zero and overflow:
  - div.w 5 / 0 → 0xFFFFFFFF; mod.w 0xFFFFFFFB / 0 → 0xFFFFFFFB.
  - div.w 0x80000000 / 0xFFFFFFFF → 0x80000000; mod.w same → 0.
- Backpressure: hold res_ready low 5 cycles in DONE → res_valid and div_result stable; div_ready stays 0; IDLE the cycle after res_ready.
- Flush:
  - div_flush at cnt == 10 → res_valid never asserts, div_busy 0 next cycle, new op accepted next cycle with correct result.
  - Flush coincident with div_valid in IDLE → not accepted.
- Reset asserted in ITER for 1 cycle → all outputs 0; div_ready 1 the cycle after deassertion; a subsequent div.wu 100 / 7 → 14.

Source files
------------

// File: rtl/exe_div_ctrl_pkg.sv
// Shared encodings for the EXE-stage iterative divider: op codes, FSM states
// and small decode helpers used by the decoder, EXE stage and divider.
package exe_div_ctrl_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_W  = 2'b00;
  localparam logic [1:0] MOD_W  = 2'b01;
  localparam logic [1:0] DIV_WU = 2'b10;
  localparam logic [1:0] MOD_WU = 2'b11;

  // The final iteration index; the counter wraps to zero after it.
  localparam logic [4:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_W) || (op == MOD_W);
  endfunction

  function automatic logic op_is_mod(input logic [1:0] op);
    return (op == MOD_W) || (op == MOD_WU);
  endfunction

endpackage

// File: rtl/exe_div_ctrl_div_iter_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and produce the next quotient bit.
module div_iter_step
  import exe_div_ctrl_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem,
  input  logic [DIV_WIDTH-1:0] quo,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] rem_next,
  output logic [DIV_WIDTH-1:0] quo_next
);

  logic [DIV_WIDTH:0] trial;

  // A clear borrow bit means the divisor fits, so keep the difference.
  always_comb begin
    trial = {rem, quo[DIV_WIDTH-1]} - {1'b0, divisor};
    if (!trial[DIV_WIDTH]) begin
      rem_next = trial[DIV_WIDTH-1:0];
    end else begin
      rem_next = {rem[DIV_WIDTH-2:0], quo[DIV_WIDTH-1]};
    end
    quo_next = {quo[DIV_WIDTH-2:0], ~trial[DIV_WIDTH]};
  end

endmodule

// File: rtl/exe_div_ctrl.sv
// EXE-stage divider controller: accepts div.w/mod.w/div.wu/mod.wu operands,
// runs 32 unsigned restoring steps on magnitudes, fixes up signs and holds
// the result until the consumer takes it. All outputs are registered.
module exe_div_ctrl
  import exe_div_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 div_valid,
  output logic                 div_ready,
  input  logic [1:0]           div_op,
  input  logic [DIV_WIDTH-1:0] div_src1,
  input  logic [DIV_WIDTH-1:0] div_src2,
  input  logic                 div_flush,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DIV_WIDTH-1:0] div_result,
  output logic                 div_busy
);

  div_state_e           state;
  logic                 is_mod_q;
  logic                 s1_q;
  logic                 s2_q;
  logic                 divzero_q;
  logic [DIV_WIDTH-1:0] src1_q;
  logic [DIV_WIDTH-1:0] abs2_q;
  logic [DIV_WIDTH-1:0] quo_q;
  logic [DIV_WIDTH-1:0] rem_q;
  logic [4:0]           cnt_q;

  logic                 s1_in;
  logic                 s2_in;
  logic [DIV_WIDTH-1:0] abs1_in;
  logic [DIV_WIDTH-1:0] abs2_in;
  logic [DIV_WIDTH-1:0] rem_next;
  logic [DIV_WIDTH-1:0] quo_next;
  logic [DIV_WIDTH-1:0] fix_result;

  // Operand signs and magnitudes captured at accept; 0x80000000 stays as its own magnitude.
  always_comb begin
    s1_in   = div_src1[DIV_WIDTH-1] & op_is_signed(div_op);
    s2_in   = div_src2[DIV_WIDTH-1] & op_is_signed(div_op);
    abs1_in = s1_in ? (~div_src1 + 1'b1) : div_src1;
    abs2_in = s2_in ? (~div_src2 + 1'b1) : div_src2;
  end

  div_iter_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (abs2_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Sign fix-up of the magnitude result; a zero divisor overrides both results.
  always_comb begin
    fix_result = '0;
    if (divzero_q) begin
      fix_result = is_mod_q ? src1_q : {DIV_WIDTH{1'b1}};
    end else if (is_mod_q) begin
      fix_result = s1_q ? (~rem_q + 1'b1) : rem_q;
    end else begin
      fix_result = (s1_q ^ s2_q) ? (~quo_q + 1'b1) : quo_q;
    end
  end

  // Divider FSM with registered handshakes; reset beats flush, flush beats everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      div_ready  <= 1'b0;
      res_valid  <= 1'b0;
      div_result <= '0;
      div_busy   <= 1'b0;
      is_mod_q   <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      divzero_q  <= 1'b0;
      src1_q     <= '0;
      abs2_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
    end else if (div_flush) begin
      state     <= ST_IDLE;
      div_ready <= 1'b1;
      res_valid <= 1'b0;
      div_busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (div_valid && div_ready) begin
            state     <= ST_ITER;
            div_ready <= 1'b0;
            div_busy  <= 1'b1;
            is_mod_q  <= op_is_mod(div_op);
            s1_q      <= s1_in;
            s2_q      <= s2_in;
            divzero_q <= (div_src2 == '0);
            src1_q    <= div_src1;
            abs2_q    <= abs2_in;
            quo_q     <= abs1_in;
            rem_q     <= '0;
            cnt_q     <= '0;
          end else begin
            div_ready <= 1'b1;
          end
        end
        ST_ITER: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          div_result <= fix_result;
          res_valid  <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            div_busy  <= 1'b0;
            div_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          div_ready <= 1'b1;
          res_valid <= 1'b0;
          div_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
